// File: rtl/adc_pkg.sv
// Shared constants and state encoding for the LTC1407A capture block.
// Frame layout is expressed as arrival indices, counted from the first SCK rise.
package adc_pkg;

  localparam int FRAME_BITS = 34;
  localparam int A_MSB_IDX  = 2;
  localparam int B_MSB_IDX  = 18;
  localparam int DATA_W     = 14;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } adc_state_e;

  // True when arrival index idx belongs to the field whose MSB arrives at msb_idx.
  function automatic logic in_field(input logic [BIT_W-1:0] idx, input int msb_idx);
    return (int'(idx) >= msb_idx) && (int'(idx) < msb_idx + DATA_W);
  endfunction

endpackage

// File: rtl/sck_divider.sv
// SPI serial clock generator: SCK_HALF cycles low then SCK_HALF cycles high per period.
// Held in reset while rst is high; the strobes are suppressed in reset.
module sck_divider #(
  parameter int SCK_HALF = 2
) (
  input  logic clk,
  input  logic rst,
  output logic sck,
  output logic rise_stb,
  output logic period_end
);

  localparam int PERIOD  = 2 * SCK_HALF;
  localparam int PHASE_W = $clog2(PERIOD);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PERIOD - 1);
  localparam logic [PHASE_W-1:0] RISE_PHASE = PHASE_W'(SCK_HALF - 1);
  localparam logic [PHASE_W-1:0] HIGH_PHASE = PHASE_W'(SCK_HALF);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               sck_q, sck_d;

  // SCK is registered from the next phase so the pin changes exactly at the phase boundary.
  always_comb begin
    phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + PHASE_W'(1);
    sck_d   = (phase_d >= HIGH_PHASE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      sck_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      sck_q   <= sck_d;
    end
  end

  assign sck        = sck_q;
  assign rise_stb   = !rst && (phase_q == RISE_PHASE);
  assign period_end = !rst && (phase_q == PHASE_LAST);

endmodule

// File: rtl/adc_capture.sv
// LTC1407A capture: periodic AD_CONV pulse, 34-bit serial frame read over SPI_SCK/AD_DOUT,
// two 14-bit two's-complement samples presented with a one-cycle sample_valid strobe.
module adc_capture
  import adc_pkg::*;
#(
  parameter int SCK_HALF      = 2,
  parameter int SAMPLE_PERIOD = 200,
  parameter int DATA_W        = adc_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              AD_DOUT,
  output logic              AD_CONV,
  output logic              SPI_SCK,
  output logic              busy,
  output logic [DATA_W-1:0] sample_a,
  output logic [DATA_W-1:0] sample_b,
  output logic              sample_valid,
  output adc_state_e        dbg_state
);

  localparam int PER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);
  localparam int CONV_CYCLES = 2 * SCK_HALF;
  localparam int CONV_W      = $clog2(CONV_CYCLES);
  localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'(CONV_CYCLES - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS - 1);

  adc_state_e         state_q, state_d;
  logic [PER_W-1:0]   period_cnt_q, period_cnt_d;
  logic [CONV_W-1:0]  conv_cnt_q, conv_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]  shift_a_q, shift_a_d;
  logic [DATA_W-1:0]  shift_b_q, shift_b_d;
  logic [DATA_W-1:0]  sample_a_q, sample_a_d;
  logic [DATA_W-1:0]  sample_b_q, sample_b_d;
  logic               ad_conv_q, ad_conv_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;

  logic start;
  logic div_rst;
  logic sck;
  logic sck_rise;
  logic sck_period_end;

  assign start   = (state_q == ST_IDLE) && enable && (period_cnt_q == PER_LAST);
  assign div_rst = rst || (state_q != ST_SHIFT);

  sck_divider #(
    .SCK_HALF (SCK_HALF)
  ) u_sck_divider (
    .clk        (clk),
    .rst        (div_rst),
    .sck        (sck),
    .rise_stb   (sck_rise),
    .period_end (sck_period_end)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_CONV;
      ST_CONV:  if (conv_cnt_q == CONV_LAST) state_d = ST_SHIFT;
      ST_SHIFT: if (sck_period_end && (bit_cnt_q == BIT_LAST)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Counters and the two field shifters; bit_cnt_q is the arrival index during its SCK period.
  always_comb begin
    period_cnt_d = period_cnt_q;
    if (start) begin
      period_cnt_d = '0;
    end else if (period_cnt_q != PER_LAST) begin
      period_cnt_d = period_cnt_q + PER_W'(1);
    end

    conv_cnt_d = '0;
    if ((state_q == ST_CONV) && (conv_cnt_q != CONV_LAST)) begin
      conv_cnt_d = conv_cnt_q + CONV_W'(1);
    end

    bit_cnt_d = '0;
    if (state_q == ST_SHIFT) begin
      bit_cnt_d = sck_period_end ? bit_cnt_q + BIT_W'(1) : bit_cnt_q;
    end

    shift_a_d = shift_a_q;
    shift_b_d = shift_b_q;
    if (sck_rise && in_field(bit_cnt_q, A_MSB_IDX)) begin
      shift_a_d = {shift_a_q[DATA_W-2:0], AD_DOUT};
    end
    if (sck_rise && in_field(bit_cnt_q, B_MSB_IDX)) begin
      shift_b_d = {shift_b_q[DATA_W-2:0], AD_DOUT};
    end
  end

  // Outputs are registered from the next state so each pin is a flop with no decode glitches.
  // sample_valid is a one-cycle strobe with no back-pressure: the consumer must take
  // sample_a/sample_b in the cycle it is high (they then hold until the next strobe).
  always_comb begin
    sample_a_d = sample_a_q;
    sample_b_d = sample_b_q;
    if (state_d == ST_DONE) begin
      sample_a_d = shift_a_q;
      sample_b_d = shift_b_q;
    end
    ad_conv_d = (state_d == ST_CONV);
    busy_d    = (state_d != ST_IDLE);
    valid_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      period_cnt_q <= PER_LAST;
      conv_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_a_q    <= '0;
      shift_b_q    <= '0;
      sample_a_q   <= '0;
      sample_b_q   <= '0;
      ad_conv_q    <= 1'b0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      conv_cnt_q   <= conv_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_a_q    <= shift_a_d;
      shift_b_q    <= shift_b_d;
      sample_a_q   <= sample_a_d;
      sample_b_q   <= sample_b_d;
      ad_conv_q    <= ad_conv_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
    end
  end

  assign AD_CONV      = ad_conv_q;
  assign SPI_SCK      = sck;
  assign busy         = busy_q;
  assign sample_a     = sample_a_q;
  assign sample_b     = sample_b_q;
  assign sample_valid = valid_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_adc_capture.sv
// Self-checking bench for adc_capture: a behavioural LTC1407A model serves random and
// corner-case frames; per-scenario tasks check timing, captured values, enable and reset.
module tb_adc_capture;
  import adc_pkg::*;

  localparam int SCK_HALF  = 2;
  localparam int PERIOD_A  = 200;
  localparam int PERIOD_B  = 50;
  localparam int NBITS     = 34;
  localparam int CONV_LEN  = 2 * SCK_HALF;
  localparam int VALID_OFS = CONV_LEN + NBITS * 2 * SCK_HALF;
  localparam int W         = 28;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic ad_dout = 1'b0;
  logic ad_dout2 = 1'b0;

  logic        ad_conv, spi_sck, busy, sample_valid;
  logic [13:0] sample_a, sample_b;
  adc_state_e  dbg_state;
  logic        ad_conv2, spi_sck2, busy2, sample_valid2;
  logic [13:0] sample_a2, sample_b2;
  adc_state_e  dbg_state2;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t0 = 0;
  int last_t0 = 0;

  logic [W-1:0] exp_q[$];
  int           conv2_q[$];
  bit           frame_bits [NBITS];

  int          w_conv_hi, w_sck_rises, w_valid_cnt, w_valid_ofs, w_busy_bad, w_sck_bad;
  logic [13:0] w_a, w_b;

  adc_capture #(.SCK_HALF(SCK_HALF), .SAMPLE_PERIOD(PERIOD_A)) dut (
    .clk(clk), .rst(rst), .enable(enable), .AD_DOUT(ad_dout),
    .AD_CONV(ad_conv), .SPI_SCK(spi_sck), .busy(busy),
    .sample_a(sample_a), .sample_b(sample_b), .sample_valid(sample_valid),
    .dbg_state(dbg_state)
  );

  adc_capture #(.SCK_HALF(SCK_HALF), .SAMPLE_PERIOD(PERIOD_B)) dut_short (
    .clk(clk), .rst(rst), .enable(enable), .AD_DOUT(ad_dout2),
    .AD_CONV(ad_conv2), .SPI_SCK(spi_sck2), .busy(busy2),
    .sample_a(sample_a2), .sample_b(sample_b2), .sample_valid(sample_valid2),
    .dbg_state(dbg_state2)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ADC model: bit k is presented until the k-th SCK rise has been seen, restarting on AD_CONV.
  int adc_k = NBITS;
  bit adc_sck_prev = 1'b0;
  always @(negedge clk) begin
    if (ad_conv) adc_k = 0;
    else if (spi_sck && !adc_sck_prev) adc_k = adc_k + 1;
    adc_sck_prev = spi_sck;
    ad_dout = (adc_k < NBITS) ? frame_bits[adc_k] : 1'b0;
  end

  bit conv2_prev = 1'b0;
  always @(negedge clk) begin
    if (ad_conv2 && !conv2_prev) conv2_q.push_back(cyc);
    conv2_prev = ad_conv2;
  end

  function automatic int exp_spacing(input int period);
    // one frame through its DONE cycle, then at least one IDLE cycle
    return (period > VALID_OFS + 2) ? period : VALID_OFS + 2;
  endfunction

  // Driver: lay out A at indices 2..15 and B at 18..31 MSB first; ign_mode 0=zeros 1=ones 2=random.
  task automatic build_frame(input logic [13:0] a, input logic [13:0] b, input int ign_mode);
    for (int k = 0; k < NBITS; k++) begin
      if (k >= 2 && k <= 15)       frame_bits[k] = a[13 - (k - 2)];
      else if (k >= 18 && k <= 31) frame_bits[k] = b[13 - (k - 18)];
      else if (ign_mode == 0)      frame_bits[k] = 1'b0;
      else if (ign_mode == 1)      frame_bits[k] = 1'b1;
      else                         frame_bits[k] = 1'($urandom_range(0, 1));
    end
    exp_q.push_back({a, b});
  endtask

  task automatic wait_conv(input int budget, output bit found);
    logic prev;
    prev = ad_conv;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (ad_conv && !prev) found = 1'b1;
      prev = ad_conv;
    end
    if (found) t0 = cyc;
  endtask

  // Observe offsets 0..VALID_OFS+1 from an AD_CONV rise; optionally drop enable at drop_at.
  task automatic watch_frame(input int drop_at);
    logic prev_sck;
    prev_sck = spi_sck;
    w_conv_hi = 0; w_sck_rises = 0; w_valid_cnt = 0; w_valid_ofs = -1;
    w_busy_bad = 0; w_sck_bad = 0; w_a = '0; w_b = '0;
    for (int ofs = 0; ofs <= VALID_OFS + 1; ofs++) begin
      if (ofs > 0) @(negedge clk);
      if (ofs == drop_at) enable = 1'b0;
      if (ad_conv) w_conv_hi++;
      if (spi_sck && !prev_sck) w_sck_rises++;
      if (spi_sck && (ofs < CONV_LEN || ofs >= VALID_OFS)) w_sck_bad++;
      prev_sck = spi_sck;
      if (busy !== (ofs <= VALID_OFS)) w_busy_bad++;
      if (sample_valid) begin
        w_valid_cnt++;
        if (w_valid_ofs < 0) begin
          w_valid_ofs = ofs;
          w_a = sample_a;
          w_b = sample_b;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ad_conv, spi_sck, busy, sample_valid} !== 4'b0000)
      $display("FAIL reset_ctrl: got %b expected 0000", {ad_conv, spi_sck, busy, sample_valid});
    if ({ad_conv, spi_sck, busy, sample_valid} !== 4'b0000) errors++;
    checks++;
    if ({sample_a, sample_b} !== 28'h0) begin
      errors++;
      $display("FAIL reset_samples: got %h/%h expected 0/0", sample_a, sample_b);
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
    end
    checks++;
    if ({ad_conv2, spi_sck2, busy2, sample_valid2, sample_a2, sample_b2} !== 32'h0 || dbg_state2 !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_short: got %b %h %h expected zeros", {ad_conv2, spi_sck2, busy2, sample_valid2}, sample_a2, sample_b2);
    end
  endtask

  task automatic test_single_frame();
    bit found;
    int t_en, busy_hi_en0;
    logic [W-1:0] exp;
    build_frame(14'h1ABC, 14'h2345, 0);
    rst = 1'b0;
    busy_hi_en0 = 0;
    repeat (5) begin
      @(negedge clk);
      if (ad_conv || busy) busy_hi_en0++;
    end
    checks++;
    if (busy_hi_en0 != 0) begin
      errors++;
      $display("FAIL idle_gated: got %0d active cycles expected 0", busy_hi_en0);
    end
    enable = 1'b1;
    t_en = cyc;
    wait_conv(10, found);
    checks++;
    if (!found || cyc - t_en != 1) begin
      errors++;
      $display("FAIL first_start: got offset %0d (found=%0d) expected 1", cyc - t_en, found);
    end
    watch_frame(-1);
    exp = exp_q.pop_front();
    checks++;
    if (w_conv_hi != CONV_LEN) begin
      errors++;
      $display("FAIL conv_width: got %0d expected %0d", w_conv_hi, CONV_LEN);
    end
    checks++;
    if (w_sck_rises != NBITS) begin
      errors++;
      $display("FAIL sck_rises: got %0d expected %0d", w_sck_rises, NBITS);
    end
    checks++;
    if (w_valid_cnt != 1 || w_valid_ofs != VALID_OFS) begin
      errors++;
      $display("FAIL valid_timing: got count %0d at %0d expected 1 at %0d", w_valid_cnt, w_valid_ofs, VALID_OFS);
    end
    checks++;
    if (w_busy_bad != 0 || w_sck_bad != 0) begin
      errors++;
      $display("FAIL busy_sck_window: got %0d busy and %0d sck bad cycles expected 0", w_busy_bad, w_sck_bad);
    end
    checks++;
    if ({w_a, w_b} !== exp) begin
      errors++;
      $display("FAIL single_values: got %h/%h expected %h/%h", w_a, w_b, exp[27:14], exp[13:0]);
    end
    checks++;
    if ({sample_a, sample_b} !== exp || sample_valid !== 1'b0) begin
      errors++;
      $display("FAIL sample_hold: got %h/%h valid=%b expected %h/%h valid=0", sample_a, sample_b, sample_valid, exp[27:14], exp[13:0]);
    end
    last_t0 = t0;
  endtask

  task automatic test_free_run();
    bit found;
    logic [W-1:0] exp;
    conv2_q.delete();
    for (int i = 0; i < 3; i++) begin
      build_frame(14'($urandom_range(0, 16383)), 14'($urandom_range(0, 16383)), 2);
      wait_conv(PERIOD_A + 20, found);
      checks++;
      if (!found || t0 - last_t0 != exp_spacing(PERIOD_A)) begin
        errors++;
        $display("FAIL spacing_200[%0d]: got %0d (found=%0d) expected %0d", i, t0 - last_t0, found, exp_spacing(PERIOD_A));
      end
      last_t0 = t0;
      watch_frame(-1);
      exp = exp_q.pop_front();
      checks++;
      if (w_valid_cnt != 1 || w_valid_ofs != VALID_OFS || {w_a, w_b} !== exp) begin
        errors++;
        $display("FAIL random_frame[%0d]: got %h/%h at %0d expected %h/%h at %0d", i, w_a, w_b, w_valid_ofs, exp[27:14], exp[13:0], VALID_OFS);
      end
    end
    checks++;
    if (conv2_q.size() < 3) begin
      errors++;
      $display("FAIL short_period_starts: got %0d starts expected at least 3", conv2_q.size());
    end
    for (int j = 1; j < conv2_q.size(); j++) begin
      checks++;
      if (conv2_q[j] - conv2_q[j-1] != exp_spacing(PERIOD_B)) begin
        errors++;
        $display("FAIL spacing_50[%0d]: got %0d expected %0d", j, conv2_q[j] - conv2_q[j-1], exp_spacing(PERIOD_B));
      end
    end
  endtask

  task automatic test_full_scale();
    bit found;
    logic [W-1:0] exp;
    logic [13:0] a_tab [3] = '{14'h2000, 14'h0000, 14'h3FFF};
    logic [13:0] b_tab [3] = '{14'h1FFF, 14'h3FFF, 14'h0000};
    for (int i = 0; i < 3; i++) begin
      build_frame(a_tab[i], b_tab[i], 1);
      wait_conv(PERIOD_A + 20, found);
      checks++;
      if (!found || t0 - last_t0 != exp_spacing(PERIOD_A)) begin
        errors++;
        $display("FAIL full_scale_start[%0d]: got %0d expected %0d", i, t0 - last_t0, exp_spacing(PERIOD_A));
      end
      last_t0 = t0;
      watch_frame(-1);
      exp = exp_q.pop_front();
      checks++;
      if (w_valid_cnt != 1 || {w_a, w_b} !== exp) begin
        errors++;
        $display("FAIL full_scale[%0d]: got %h/%h expected %h/%h", i, w_a, w_b, exp[27:14], exp[13:0]);
      end
    end
  endtask

  task automatic test_enable_drop();
    bit found;
    int late;
    logic [W-1:0] exp;
    build_frame(14'($urandom_range(0, 16383)), 14'($urandom_range(0, 16383)), 2);
    wait_conv(PERIOD_A + 20, found);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL drop_start: got no AD_CONV expected one");
    end
    watch_frame(60);
    exp = exp_q.pop_front();
    checks++;
    if (w_valid_cnt != 1 || w_valid_ofs != VALID_OFS || {w_a, w_b} !== exp) begin
      errors++;
      $display("FAIL drop_completes: got %h/%h at %0d expected %h/%h at %0d", w_a, w_b, w_valid_ofs, exp[27:14], exp[13:0], VALID_OFS);
    end
    late = 0;
    repeat (400) begin
      @(negedge clk);
      if (ad_conv || busy) late++;
    end
    checks++;
    if (late != 0) begin
      errors++;
      $display("FAIL drop_no_restart: got %0d active cycles expected 0", late);
    end
  endtask

  task automatic test_enable_off();
    int active;
    rst = 1'b1;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    active = 0;
    repeat (1000) begin
      @(negedge clk);
      if (ad_conv || spi_sck) active++;
    end
    checks++;
    if (active != 0) begin
      errors++;
      $display("FAIL enable_off: got %0d active cycles expected 0", active);
    end
  endtask

  task automatic test_rst_mid();
    bit found;
    int t_en, t_abort, valids;
    logic [W-1:0] exp;
    build_frame(14'($urandom_range(0, 16383)), 14'($urandom_range(0, 16383)), 2);
    enable = 1'b1;
    t_en = cyc;
    wait_conv(10, found);
    checks++;
    if (!found || cyc - t_en != 1) begin
      errors++;
      $display("FAIL reenable_start: got offset %0d expected 1", cyc - t_en);
    end
    t_abort = t0;
    valids = 0;
    for (int ofs = 1; ofs <= 70; ofs++) begin
      @(negedge clk);
      if (sample_valid) valids++;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({ad_conv, spi_sck, busy, sample_valid, sample_a, sample_b} !== 32'h0) begin
      errors++;
      $display("FAIL abort_outputs: got %b %h %h expected zeros", {ad_conv, spi_sck, busy, sample_valid}, sample_a, sample_b);
    end
    checks++;
    if (valids != 0) begin
      errors++;
      $display("FAIL abort_no_valid: got %0d strobes expected 0", valids);
    end
    rst = 1'b0;
    exp_q.delete();
    build_frame(14'($urandom_range(0, 16383)), 14'($urandom_range(0, 16383)), 2);
    wait_conv(10, found);
    checks++;
    if (!found || t0 - t_abort != 72) begin
      errors++;
      $display("FAIL restart_after_rst: got offset %0d expected 72", t0 - t_abort);
    end
    watch_frame(-1);
    exp = exp_q.pop_front();
    checks++;
    if (w_valid_cnt != 1 || w_valid_ofs != VALID_OFS || {w_a, w_b} !== exp) begin
      errors++;
      $display("FAIL restart_frame: got %h/%h at %0d expected %h/%h at %0d", w_a, w_b, w_valid_ofs, exp[27:14], exp[13:0], VALID_OFS);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_free_run();
    test_full_scale();
    test_enable_drop();
    test_enable_off();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
